vending_machine_multi: RTL and testbench
========================================

Name: vending_machine_multi

Overview:
Parametrised successor to the two-product vending controller: N product channels, configurable price, bounded credit register, per-channel stock counters with sold-out flags, and multi-cycle change return paid out as discrete nickel pulses. Accepts nickel/dime/quarter pulses from the coin front-end and drives per-channel dispense pulses to the product actuators. All money is counted internally in nickel units (N=1, D=2, Q=5).

Parameters:
NUM_ITEMS, 2, number of product channels
PRICE, 5, item price in nickels (5 = 25c), 1..MAX_CREDIT
MAX_CREDIT, 20, credit ceiling in nickels (20 = 1.00)
CREDIT_W, 5, credit register width; must satisfy 2^CREDIT_W > MAX_CREDIT
STOCK_W, 4, per-channel stock counter width
INIT_STOCK, 10, stock loaded per channel at reset, < 2^STOCK_W

Ports:
CLK  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
ni  in  1  nickel inserted, one-cycle pulse
di  in  1  dime inserted, one-cycle pulse
qu  in  1  quarter inserted, one-cycle pulse
sel  in  NUM_ITEMS  product request, sampled per cycle
cancel  in  1  coin-return request (used only with VEND_COIN_RETURN_EN)
give  out  NUM_ITEMS  one-hot dispense, one-cycle pulse
change  out  1  one nickel returned per high cycle
coin_reject  out  1  coin bounced, one-cycle pulse
sold_out  out  NUM_ITEMS  channel stock == 0, level
credit  out  CREDIT_W  current credit in nickels
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, credit=0, give=0, change=0, coin_reject=0, busy=0, every stock=INIT_STOCK, sold_out=0 (or 1 where INIT_STOCK=0). Reset mid-vend or mid-change abandons the transaction; credit is lost.
- All outputs are registered.
- States: IDLE, VEND, CHG_HI, CHG_LO.
- IDLE, coin: if several coin inputs are high, priority is qu > di > ni; the lower-priority coins are rejected. Accept if credit+value <= MAX_CREDIT; otherwise pulse coin_reject next cycle and leave credit unchanged. Credit updates on the next edge.
- IDLE, selection: valid only when no coin input is high that cycle; a coin in the same cycle wins and sel is ignored. With multi-hot sel, the lowest index wins. Requires credit >= PRICE and stock[i] != 0; otherwise ignored, no error output.
- IDLE to VEND on a valid selection, then for one cycle: give[i]=1, credit -= PRICE, stock[i] -= 1. The dispense pulse appears 1 cycle after sel is sampled.
- VEND to CHG_HI if remaining credit > 0, else IDLE.
- CHG_HI: change=1, credit -= 1, go to CHG_LO.
- CHG_LO: change=0. Go to CHG_HI if credit > 0, else IDLE. Change pulses are therefore 1 cycle high, 1 cycle low.
- Outside IDLE: any coin pulses coin_reject and is not credited; sel and cancel are ignored.
- sold_out[i] updates the cycle after stock[i] reaches 0. A stock counter never wraps below 0.
- Arithmetic uses CREDIT_W bits; the overflow compare uses CREDIT_W+1 bits so the sum cannot wrap.

Optional Feature:
Macro VEND_COIN_RETURN_EN.
- Defined: cancel high in IDLE with credit > 0 goes to CHG_HI and returns all credit as nickel pulses. Cancel takes priority over sel in the same cycle; coins in the same cycle are rejected.
- Not defined: cancel is ignored, and credit persists until a purchase.

Decomposition:
- Package vend_pkg: coin values (NICKEL_VAL=1, DIME_VAL=2, QUARTER_VAL=5) and the state encoding constants (IDLE, VEND, CHG_HI, CHG_LO).
- Sub-module vend_stock_counter, generated NUM_ITEMS times. Inputs: CLK, rst, dec; outputs: count and empty. It loads INIT_STOCK on reset and saturates at 0.

Test Plan:
- Defaults; 5 ni pulses then 1 di, 2 cycles apart, then sel=2'b01 -> credit goes 1..5, then 7; give=2'b01 one cycle later; then exactly 2 change pulses, 1 high/1 low; credit=0; busy low.
- qu x4 (credit 20), then qu -> coin_reject pulse, credit stays 20; sel=2'b10 -> give[1], then 15 change pulses.
- Credit=3, sel=2'b01 -> no give, credit stays 3. Add di (credit 5), sel -> give[0], no change pulses.
- INIT_STOCK=1: buy item 0 twice with 25c each -> second sel ignored; sold_out[0]=1 after the first vend; credit stays 5.
- During the change phase, pulse ni -> coin_reject, change count unaffected. Assert rst mid-change -> all outputs 0 and credit 0 immediately; stock reloaded.
- With VEND_COIN_RETURN_EN defined: credit=7, cancel and sel together -> 7 change pulses, no give. With the macro undefined, cancel has no effect.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: coin values in nickel units and the vending FSM state encoding.
package vend_pkg;
  localparam int NICKEL_VAL = 1;
  localparam int DIME_VAL = 2;
  localparam int QUARTER_VAL = 5;
  typedef enum logic [1:0] {IDLE, VEND, CHG_HI, CHG_LO} state_t;
endpackage

// File: rtl/vend_stock_counter.sv
// vend_stock_counter: per-channel stock, loaded at reset, saturating at zero, registered empty flag.
module vend_stock_counter #(
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 10
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               dec,
  output logic [STOCK_W-1:0] count,
  output logic               empty
);
  logic [STOCK_W-1:0] count_q;
  logic               empty_q;
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      count_q <= STOCK_W'(INIT_STOCK);
      empty_q <= (INIT_STOCK == 0);
    end else begin
      if (dec && count_q != '0) count_q <= count_q - STOCK_W'(1);
      empty_q <= (count_q == '0);
    end
  end
  assign count = count_q;
  assign empty = empty_q;
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: N-channel vending controller with nickel-pulse change; VEND_COIN_RETURN_EN enables cancel.
module vending_machine_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 2,
  parameter int PRICE = 5,
  parameter int MAX_CREDIT = 20,
  parameter int CREDIT_W = 5,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 10
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 ni,
  input  logic                 di,
  input  logic                 qu,
  input  logic [NUM_ITEMS-1:0] sel,
  input  logic                 cancel,
  output logic [NUM_ITEMS-1:0] give,
  output logic                 change,
  output logic                 coin_reject,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy
);
  state_t               state_q;
  logic [CREDIT_W-1:0]  credit_q, coin_val;
  logic [CREDIT_W:0]    sum;
  logic [NUM_ITEMS-1:0] give_q, pick, nz, dec;
  logic                 change_q, coin_reject_q, busy_q;
  logic                 any_coin, multi_coin, fits, cancel_go, sel_go;
  logic [STOCK_W-1:0]   stock [NUM_ITEMS];

  assign any_coin = ni | di | qu;
  assign multi_coin = (ni & di) | (ni & qu) | (di & qu);
  assign coin_val = CREDIT_W'(qu ? QUARTER_VAL : di ? DIME_VAL : ni ? NICKEL_VAL : 0);
  // one bit wider so the ceiling compare cannot wrap
  assign sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign fits = sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign pick = sel & (~sel + NUM_ITEMS'(1));
`ifdef VEND_COIN_RETURN_EN
  assign cancel_go = (state_q == IDLE) & cancel & (credit_q != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_go = 1'b0;
`endif
  assign sel_go = (state_q == IDLE) & ~any_coin & ~cancel_go & (|pick) &
                  (credit_q >= CREDIT_W'(PRICE)) & (|(pick & nz));
  assign dec = sel_go ? pick : '0;

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_stock
    vend_stock_counter #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_cnt (
      .CLK(CLK), .rst(rst), .dec(dec[i]), .count(stock[i]), .empty(sold_out[i])
    );
    assign nz[i] = |stock[i];
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      give_q <= '0;
      change_q <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      give_q <= '0;
      change_q <= 1'b0;
      coin_reject_q <= any_coin & ((state_q != IDLE) | cancel_go | multi_coin | ~fits);
      case (state_q)
        IDLE: begin
          if (cancel_go) begin
            state_q <= CHG_HI;
            change_q <= 1'b1;
            credit_q <= credit_q - CREDIT_W'(1);
            busy_q <= 1'b1;
          end else if (any_coin) begin
            if (fits) credit_q <= sum[CREDIT_W-1:0];
          end else if (sel_go) begin
            state_q <= VEND;
            give_q <= pick;
            credit_q <= credit_q - CREDIT_W'(PRICE);
            busy_q <= 1'b1;
          end
        end
        CHG_HI: state_q <= CHG_LO;
        default: begin
          if (credit_q != '0) begin
            state_q <= CHG_HI;
            change_q <= 1'b1;
            credit_q <= credit_q - CREDIT_W'(1);
          end else begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign give = give_q;
  assign change = change_q;
  assign coin_reject = coin_reject_q;
  assign credit = credit_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed checks of the default two-channel vending controller.
module tb_vending_machine_multi;
  logic       CLK = 1'b0, rst = 1'b0, ni = 1'b0, di = 1'b0, qu = 1'b0, cancel = 1'b0;
  logic [1:0] sel = '0;
  logic [1:0] give, sold_out;
  logic       change, coin_reject, busy;
  logic [4:0] credit;
  int         n_chk = 0, n_fail = 0, bought0 = 0;

  vending_machine_multi dut (
    .CLK(CLK), .rst(rst), .ni(ni), .di(di), .qu(qu), .sel(sel), .cancel(cancel),
    .give(give), .change(change), .coin_reject(coin_reject), .sold_out(sold_out),
    .credit(credit), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic n, input logic d, input logic q);
    ni = n; di = d; qu = q;
    tick();
    ni = 1'b0; di = 1'b0; qu = 1'b0;
  endtask

  task automatic vend(input logic [1:0] s);
    sel = s;
    tick();
    sel = '0;
  endtask

  task automatic drain(input string tag, input int exp_n);
    int n = 0, cyc = 0, bad = 0;
    logic prev = change;
    logic [1:0] gv = '0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
      if (change) n++;
      if (change && prev) bad++;
      prev = change;
      gv |= give;
    end
    chk({tag, " timeout"}, {31'd0, busy}, 0);
    chk({tag, " pulses"}, n, exp_n);
    chk({tag, " gaps"}, bad, 0);
    chk({tag, " give"}, gv, 0);
    chk({tag, " credit"}, credit, 0);
  endtask

  initial begin
    #12;
    chk("rst credit", credit, 0);
    chk("rst give", give, 0);
    chk("rst change", change, 0);
    chk("rst reject", coin_reject, 0);
    chk("rst busy", busy, 0);
    chk("rst sold", sold_out, 0);
    @(negedge CLK) rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      coin(1, 0, 0);
      chk("nickel credit", credit, i);
      tick();
    end
    coin(0, 1, 0);
    chk("dime credit", credit, 7);
    tick();
    vend(2'b01);
    chk("t1 give", give, 2'b01);
    chk("t1 credit", credit, 2);
    chk("t1 busy", busy, 1);
    bought0++;
    drain("t1", 2);
    for (int i = 1; i <= 4; i++) coin(0, 0, 1);
    chk("q4 credit", credit, 20);
    coin(0, 0, 1);
    chk("over reject", coin_reject, 1);
    chk("over credit", credit, 20);
    tick();
    chk("reject pulse end", coin_reject, 0);
    vend(2'b10);
    chk("t2 give", give, 2'b10);
    chk("t2 credit", credit, 15);
    drain("t2", 15);
    for (int i = 0; i < 3; i++) coin(1, 0, 0);
    vend(2'b01);
    chk("short give", give, 0);
    chk("short credit", credit, 3);
    chk("short busy", busy, 0);
    coin(0, 1, 0);
    chk("t3 credit", credit, 5);
    vend(2'b01);
    chk("t3 give", give, 2'b01);
    chk("t3 credit0", credit, 0);
    bought0++;
    drain("t3", 0);
    coin(0, 0, 1);
    coin(0, 1, 0);
    vend(2'b01);
    bought0++;
    chk("t4 give", give, 2'b01);
    coin(1, 0, 0);
    chk("busy reject", coin_reject, 1);
    chk("busy change", change, 1);
    chk("busy credit", credit, 1);
    drain("t4", 1);
    coin(1, 1, 1);
    chk("prio credit", credit, 5);
    chk("prio reject", coin_reject, 1);
    ni = 1'b1; sel = 2'b01;
    tick();
    ni = 1'b0; sel = '0;
    chk("coin beats sel give", give, 0);
    chk("coin beats sel credit", credit, 6);
    chk("coin beats sel reject", coin_reject, 0);
    vend(2'b11);
    chk("multihot give", give, 2'b01);
    bought0++;
    drain("t5", 1);
    coin(0, 0, 1);
    coin(0, 1, 0);
    cancel = 1'b1; sel = 2'b01;
    tick();
    cancel = 1'b0; sel = '0;
`ifdef VEND_COIN_RETURN_EN
    chk("cancel give", give, 0);
    chk("cancel change", change, 1);
    chk("cancel credit", credit, 6);
    drain("cancel", 6);
`else
    chk("nocancel give", give, 2'b01);
    chk("nocancel credit", credit, 2);
    bought0++;
    drain("nocancel", 2);
`endif
    while (bought0 < 10) begin
      coin(0, 0, 1);
      vend(2'b01);
      chk("stock give", give, 2'b01);
      bought0++;
      if (bought0 < 10) tick();
    end
    chk("sold lag", sold_out, 0);
    tick();
    chk("sold set", sold_out, 2'b01);
    coin(0, 0, 1);
    vend(2'b01);
    chk("soldout give", give, 0);
    chk("soldout credit", credit, 5);
    chk("soldout busy", busy, 0);
    vend(2'b10);
    chk("other give", give, 2'b10);
    tick();
    coin(0, 0, 1);
    coin(0, 1, 0);
    vend(2'b10);
    tick();
    chk("pre-rst change", change, 1);
    #2 rst = 1'b0;
    #1;
    chk("async change", change, 0);
    chk("async credit", credit, 0);
    chk("async busy", busy, 0);
    chk("async give", give, 0);
    chk("async sold", sold_out, 0);
    @(negedge CLK) rst = 1'b1;
    coin(0, 0, 1);
    vend(2'b01);
    chk("reload give", give, 2'b01);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
